// File: rtl/serial_rbs_pkg.sv
// ---------------------------------------------------------------------------
// | Package : serial_rbs_pkg                                                |
// | Shared state encoding and sizing helper for the bit-serial subtractor.  |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package serial_rbs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rbs_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// | Module  : full_subtractor                                               |
// | One-bit full subtractor: d = m - s - bi, with borrow-out bo.            |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module full_subtractor (
  input  logic m,
  input  logic s,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = m ^ s ^ bi;
  assign bo = (~m & s) | (~(m ^ s) & bi);

endmodule

`default_nettype wire

// File: rtl/serial_rbs_inverter.sv
// ---------------------------------------------------------------------------
// | Module  : serial_rbs_inverter                                           |
// | Bit-serial ripple-borrow subtractor recovering a = sum - b - cin.       |
// | Optional macro RBS_SELFCHECK_EN adds a parallel reference and chk_err.  |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module serial_rbs_inverter
  import serial_rbs_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             range_err
`ifdef RBS_SELFCHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int             CW     = cnt_w(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH);

  rbs_state_t       r_state, w_state_nxt;
  logic [WIDTH:0]   r_m, r_s, r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_range_err;
  logic             w_d, w_bo, w_last;
  logic [WIDTH:0]   w_res_nxt;

  full_subtractor u_fs (
    .m  (r_m[0]),
    .s  (r_s[0]),
    .bi (r_br),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_last    = (r_cnt == C_LAST);
  assign w_res_nxt = {w_d, r_res[WIDTH:1]};
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign range_err = r_range_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = SHIFT;
      SHIFT:   if (w_last)   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m         <= '0;
      r_s         <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_br        <= 1'b0;
      r_diff      <= '0;
      r_range_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_m   <= minuend;
            r_s   <= {1'b0, subtrahend};
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_m   <= r_m >> 1;
          r_s   <= r_s >> 1;
          r_br  <= w_bo;
          r_res <= w_res_nxt;
          if (w_last) begin
            // Final borrow means negative; a set MSB means the result overflowed WIDTH bits.
            r_diff      <= w_res_nxt[WIDTH-1:0];
            r_range_err <= w_bo | w_res_nxt[WIDTH];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RBS_SELFCHECK_EN
  // Operands are captured at accept so the reference is immune to later input changes.
  logic [WIDTH:0]   r_ref_m;
  logic [WIDTH-1:0] r_ref_s;
  logic             r_ref_b;
  logic             r_chk_err;
  logic [WIDTH+1:0] w_ref;
  logic             w_mismatch;

  assign w_ref      = (WIDTH+2)'(r_ref_m) - (WIDTH+2)'(r_ref_s) - (WIDTH+2)'(r_ref_b);
  assign w_mismatch = (r_diff != w_ref[WIDTH-1:0]) ||
                      (r_range_err != (w_ref[WIDTH+1] | w_ref[WIDTH]));
  assign chk_err    = r_chk_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ref_m   <= '0;
      r_ref_s   <= '0;
      r_ref_b   <= 1'b0;
      r_chk_err <= 1'b0;
    end else begin
      if (in_ready && in_valid) begin
        r_ref_m <= minuend;
        r_ref_s <= subtrahend;
        r_ref_b <= bin;
      end
      if (out_valid && w_mismatch) r_chk_err <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_rbs_inverter.sv
// ---------------------------------------------------------------------------
// | Module  : tb_serial_rbs_inverter                                        |
// | Randomized self-checking bench against an arithmetic reference model.   |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_rbs_inverter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH:0]   minuend = '0;
  logic [WIDTH-1:0] subtrahend = '0;
  logic             bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             range_err;
`ifdef RBS_SELFCHECK_EN
  logic             chk_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_rbs_inverter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .range_err  (range_err)
`ifdef RBS_SELFCHECK_EN
    ,
    .chk_err    (chk_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction; hold = cycles out_ready stays low in DONE with in_valid noise.
  task automatic run_op(input logic [WIDTH:0] m, input logic [WIDTH-1:0] s,
                        input logic b, input int hold);
    int          t;
    int          lat;
    logic [31:0] tv;
    logic [WIDTH-1:0] ed;
    logic        ee;
    t  = int'(m) - int'(s) - int'(b);
    tv = t;
    ed = tv[WIDTH-1:0];
    ee = (t < 0) || (t >= (1 << WIDTH));

    check("ready_before", 32'(in_ready), 32'd1);
    minuend    = m;
    subtrahend = s;
    bin        = b;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      in_valid   = 1'($urandom_range(0, 1));
      minuend    = 5'($urandom);
      subtrahend = 4'($urandom);
      bin        = 1'($urandom_range(0, 1));
    end
    check("latency", 32'(lat), 32'(WIDTH + 1));
    check("out_valid", 32'(out_valid), 32'd1);
    check("diff", 32'(diff), 32'(ed));
    check("range_err", 32'(range_err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      minuend    = 5'($urandom);
      subtrahend = 4'($urandom);
      @(posedge clk); #1;
      check("held_valid", 32'(out_valid), 32'd1);
      check("held_busy", 32'(in_ready), 32'd0);
      check("held_diff", 32'(diff), 32'(ed));
      check("held_err", 32'(range_err), 32'(ee));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_return", 32'(in_ready), 32'd1);
    check("diff_kept", 32'(diff), 32'(ed));
    check("err_kept", 32'(range_err), 32'(ee));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_err", 32'(range_err), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(5'b01000, 4'b0101, 1'b0, 0);
    run_op(5'b00110, 4'b0101, 1'b1, 1);
    run_op(5'b00011, 4'b0101, 1'b0, 0);
    run_op(5'b11111, 4'b0000, 1'b0, 2);
    run_op(5'b01000, 4'b0101, 1'b0, 3);

    // Abort an operation two cycles into SHIFT.
    minuend    = 5'b11111;
    subtrahend = 4'b0001;
    bin        = 1'b0;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_err", 32'(range_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_spurious_valid", 32'(out_valid), 32'd0);
    end
    run_op(5'b01000, 4'b0101, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      run_op(5'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)));
    end

`ifdef RBS_SELFCHECK_EN
    check("chk_err", 32'(chk_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
